// File: rtl/timer_pkg.sv
// Shared types and BCD constants for the mm:ss stopwatch / countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_ZERO     = 4'd0;

  // Any preset digit above the digit's range is pinned to that range's top.
  function automatic logic [3:0] clamp_digit(input logic [3:0] value,
                                             input logic [3:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/sec_timer_bcd_if.sv
// Control/status bundle between the timer and its host (buttons, display, LEDs).
interface sec_timer_bcd_if;

  logic       start;
  logic       pause;
  logic       clear;
  logic       load;
  logic       mode_down;
  logic [7:0] load_min;
  logic [7:0] load_sec;

  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       done;
  logic       wrap;
  logic       tick;

  modport master (
    output start, pause, clear, load, mode_down, load_min, load_sec,
    input  min, sec, running, done, wrap, tick
  );

  modport slave (
    input  start, pause, clear, load, mode_down, load_min, load_sec,
    output min, sec, running, done, wrap, tick
  );

endinterface

// File: rtl/sec_timer_bcd_digit.sv
// One BCD digit with its own range; carry/borrow flag the digit at its wrap point.
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic [3:0] max_val,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       carry,
  output logic       borrow
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    // NOTE: default first, so every path through the block assigns digit_d and no latch is inferred.
    digit_d = digit_q;
    if (load_en) begin
      digit_d = clamp_digit(load_val, max_val);
    end else if (en) begin
      if (up) begin
        digit_d = (digit_q >= max_val) ? BCD_ZERO : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_ZERO) ? max_val : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign carry  = up && (digit_q == max_val);
  assign borrow = !up && (digit_q == BCD_ZERO);

endmodule

// File: rtl/sec_timer_bcd.sv
// BCD mm:ss stopwatch / countdown driven by the synchronised, edge-detected 1 Hz toggle.
module sec_timer_bcd
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_1s,
  sec_timer_bcd_if.slave  bus
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   tick_q, tick_d;
  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic                   wrap_q, wrap_d;

  logic       cnt_en;
  logic       load_en;
  logic       use_preset;
  logic [3:0] digit_val  [4];
  logic [3:0] load_digit [4];
  logic [3:0] carry;
  logic [3:0] borrow;
  logic [4:0] step;
  logic       count_zero;
  logic       count_one;

  // Tick path: synchroniser chain, then a one-flop rising-edge detector.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_1s};
    edge_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // Digit order: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
  assign load_digit[0] = use_preset ? bus.load_sec[3:0] : BCD_ZERO;
  assign load_digit[1] = use_preset ? bus.load_sec[7:4] : BCD_ZERO;
  assign load_digit[2] = use_preset ? bus.load_min[3:0] : BCD_ZERO;
  assign load_digit[3] = use_preset ? bus.load_min[7:4] : BCD_ZERO;

  assign step[0] = cnt_en;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    localparam logic [3:0] MAXV = (i == 1) ? SEC_TENS_MAX :
                                  (i == 3) ? MIN_TENS_MAX : DIGIT_MAX;

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .en       (step[i]),
      .up       (~mode_q),
      .max_val  (MAXV),
      .load_en  (load_en),
      .load_val (load_digit[i]),
      .digit    (digit_val[i]),
      .carry    (carry[i]),
      .borrow   (borrow[i])
    );

    // A digit steps only when every lower digit is at its carry/borrow point.
    assign step[i+1] = step[i] & (mode_q ? borrow[i] : carry[i]);
  end

  assign count_zero = (digit_val[0] == BCD_ZERO) && (digit_val[1] == BCD_ZERO) &&
                      (digit_val[2] == BCD_ZERO) && (digit_val[3] == BCD_ZERO);
  assign count_one  = (digit_val[0] == 4'd1)     && (digit_val[1] == BCD_ZERO) &&
                      (digit_val[2] == BCD_ZERO) && (digit_val[3] == BCD_ZERO);

  // Command priority: clear > load > pause > start > tick.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_en     = 1'b0;
    load_en    = 1'b0;
    use_preset = 1'b0;

    if (bus.clear) begin
      state_d = IDLE;
      load_en = 1'b1;
    end else if (bus.load && (state_q != RUN)) begin
      state_d    = IDLE;
      load_en    = 1'b1;
      use_preset = 1'b1;
    end else if (bus.pause) begin
      // Pause swallows a simultaneous start even where it has no effect itself.
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (bus.start && ((state_q == IDLE) || (state_q == PAUSE))) begin
      mode_d  = bus.mode_down;
      state_d = (bus.mode_down && count_zero) ? DONE : RUN;
    end else if (tick_q && (state_q == RUN)) begin
      if (!mode_q) begin
        cnt_en = 1'b1;
      end else if (!count_zero) begin
        cnt_en = 1'b1;
        if (count_one) begin
          state_d = DONE;
        end
      end
    end
  end

  // step[4] in up mode means all four digits were at their maximum.
  assign wrap_d = step[4] & ~mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= IDLE;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.min     = {digit_val[3], digit_val[2]};
  assign bus.sec     = {digit_val[1], digit_val[0]};
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.wrap    = wrap_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_sec_timer_bcd.sv
// Self-checking bench for sec_timer_bcd: directed sequences, a command table, and a random run against a seconds-count model.
module tb_sec_timer_bcd;

  localparam int SYNC      = 2;
  localparam int MAXT      = 5;
  localparam int MAX_TOTAL = (MAXT * 10 + 9) * 60 + 59;

  logic clk = 1'b0;
  logic rst;
  logic clk_1s;
  int   n_cmp = 0;
  int   n_err = 0;

  sec_timer_bcd_if bus ();

  sec_timer_bcd #(.SYNC_STAGES(SYNC), .MAX_MIN_TENS(MAXT)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_1s (clk_1s),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic       start, pause, clear, load, mode_down;
    logic [7:0] load_min, load_sec;
    logic [7:0] exp_min, exp_sec;
    logic       exp_running, exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic st, logic pa, logic cl, logic ld, logic md,
                              logic [7:0] lm, logic [7:0] ls, logic [7:0] em, logic [7:0] es,
                              logic er, logic ed);
    vec_t v;
    v.name = name; v.start = st; v.pause = pa; v.clear = cl; v.load = ld; v.mode_down = md;
    v.load_min = lm; v.load_sec = ls; v.exp_min = em; v.exp_sec = es;
    v.exp_running = er; v.exp_done = ed;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] m, input logic [7:0] s,
                            input logic r, input logic d, input logic w, input logic t);
    n_cmp++;
    if ({bus.min, bus.sec, bus.running, bus.done, bus.wrap, bus.tick} !== {m, s, r, d, w, t}) begin
      n_err++;
      $display("FAIL %s: got %h:%h run=%b done=%b wrap=%b tick=%b want %h:%h run=%b done=%b wrap=%b tick=%b",
               name, bus.min, bus.sec, bus.running, bus.done, bus.wrap, bus.tick, m, s, r, d, w, t);
    end
  endtask

  task automatic idle_cmds();
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
  endtask

  task automatic do_start(input logic md);
    bus.mode_down = md; bus.start = 1'b1; cycle(); bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1; cycle(); bus.pause = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    bus.load_min = m; bus.load_sec = s; bus.load = 1'b1; cycle(); bus.load = 1'b0;
  endtask

  // Leaves the bench in the cycle where tick is visible, so the caller can add commands.
  task automatic tick_arm();
    clk_1s = 1'b0;
    repeat (SYNC + 2) cycle();
    clk_1s = 1'b1;
    for (int i = 0; i < SYNC + 4; i++) begin
      if (bus.tick) break;
      cycle();
    end
    check("tick_arrives", bus.tick, 1'b1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_arm();
      cycle();
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int clampi(input logic [3:0] d, input int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  // Random-run reference model: the count is a plain number of seconds.
  int             m_tot;
  int             m_state;  // 0 idle, 1 run, 2 pause, 3 done
  logic           m_down;
  logic [SYNC+1:0] hist;
  logic           m_tick;
  logic           m_wrap;

  initial begin
    int tick_cnt;

    idle_cmds();
    bus.mode_down = 1'b0; bus.load_min = 8'h00; bus.load_sec = 8'h00;
    clk_1s = 1'b0;
    rst = 1'b1;
    cycle(); cycle();
    check_outs("reset_state", 8'h00, 8'h00, 0, 0, 0, 0);
    rst = 1'b0;

    // Tick latency and count: three rising edges of clk_1s.
    tick_cnt = 0;
    for (int e = 0; e < 3; e++) begin
      clk_1s = 1'b0;
      repeat (SYNC + 2) begin cycle(); tick_cnt += int'(bus.tick); end
      clk_1s = 1'b1;
      for (int k = 1; k <= SYNC + 2; k++) begin
        cycle();
        tick_cnt += int'(bus.tick);
        check("tick_latency", bus.tick, (k == SYNC + 1) ? 1'b1 : 1'b0);
      end
      repeat (3) begin cycle(); tick_cnt += int'(bus.tick); end
    end
    clk_1s = 1'b0;
    repeat (SYNC + 3) begin cycle(); tick_cnt += int'(bus.tick); end
    check("tick_count", tick_cnt, 3);
    check_outs("idle_after_ticks", 8'h00, 8'h00, 0, 0, 0, 0);

    // Command table, applied with no ticks in flight.
    vecs.push_back(mk("load_clamp",         0,0,0,1,0, 8'h8A,8'h7C, 8'h59,8'h59, 0,0));
    vecs.push_back(mk("load_1234",          0,0,0,1,0, 8'h12,8'h34, 8'h12,8'h34, 0,0));
    vecs.push_back(mk("start_pause_idle",   1,1,0,0,0, 8'h00,8'h00, 8'h12,8'h34, 0,0));
    vecs.push_back(mk("start_up",           1,0,0,0,0, 8'h00,8'h00, 8'h12,8'h34, 1,0));
    vecs.push_back(mk("load_in_run",        0,0,0,1,0, 8'h00,8'h00, 8'h12,8'h34, 1,0));
    vecs.push_back(mk("pause",              0,1,0,0,0, 8'h00,8'h00, 8'h12,8'h34, 0,0));
    vecs.push_back(mk("start_pause_paused", 1,1,0,0,0, 8'h00,8'h00, 8'h12,8'h34, 0,0));
    vecs.push_back(mk("clear",              0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0));
    vecs.push_back(mk("start_down_zero",    1,0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 0,1));
    vecs.push_back(mk("start_in_done",      1,0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,1));
    vecs.push_back(mk("pause_in_done",      0,1,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,1));
    vecs.push_back(mk("load_in_done",       0,0,0,1,0, 8'h00,8'h05, 8'h00,8'h05, 0,0));
    vecs.push_back(mk("load_clamp_ones",    0,0,0,1,0, 8'hF3,8'h0F, 8'h53,8'h09, 0,0));
    vecs.push_back(mk("clear_beats_load",   0,0,1,1,0, 8'h11,8'h11, 8'h00,8'h00, 0,0));
    foreach (vecs[i]) begin
      bus.start = vecs[i].start; bus.pause = vecs[i].pause; bus.clear = vecs[i].clear;
      bus.load = vecs[i].load; bus.mode_down = vecs[i].mode_down;
      bus.load_min = vecs[i].load_min; bus.load_sec = vecs[i].load_sec;
      cycle();
      idle_cmds();
      check_outs(vecs[i].name, vecs[i].exp_min, vecs[i].exp_sec, vecs[i].exp_running,
                 vecs[i].exp_done, 0, 0);
    end

    // Up count, pause, resume.
    do_start(1'b0);
    ticks(61);
    check_outs("up_61", 8'h01, 8'h01, 1, 0, 0, 0);
    do_pause();
    ticks(5);
    check_outs("paused_5", 8'h01, 8'h01, 0, 0, 0, 0);
    do_start(1'b0);
    ticks(1);
    check_outs("resume_1", 8'h01, 8'h02, 1, 0, 0, 0);

    // Rollover 59:59 -> 00:00.
    do_clear();
    do_load(8'h59, 8'h58);
    do_start(1'b0);
    ticks(1);
    check_outs("at_max", 8'h59, 8'h59, 1, 0, 0, 0);
    ticks(1);
    check_outs("wrap_pulse", 8'h00, 8'h00, 1, 0, 1, 0);
    cycle();
    check_outs("wrap_one_cycle", 8'h00, 8'h00, 1, 0, 0, 0);

    // Countdown to done.
    do_clear();
    do_load(8'h01, 8'h00);
    do_start(1'b1);
    bus.mode_down = 1'b0;
    ticks(59);
    check_outs("down_59", 8'h00, 8'h01, 1, 0, 0, 0);
    ticks(1);
    check_outs("down_done", 8'h00, 8'h00, 0, 1, 0, 0);
    ticks(2);
    do_start(1'b0);
    check_outs("done_sticky", 8'h00, 8'h00, 0, 1, 0, 0);
    do_clear();
    check_outs("done_cleared", 8'h00, 8'h00, 0, 0, 0, 0);

    // Ticks coinciding with commands.
    do_load(8'h00, 8'h10);
    do_start(1'b0);
    tick_arm();
    bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
    check_outs("clear_with_tick", 8'h00, 8'h00, 0, 0, 0, 0);
    tick_arm();
    bus.mode_down = 1'b0; bus.start = 1'b1; cycle(); bus.start = 1'b0;
    check_outs("start_with_tick", 8'h00, 8'h00, 1, 0, 0, 0);
    ticks(1);
    check_outs("first_tick_after_start", 8'h00, 8'h01, 1, 0, 0, 0);
    tick_arm();
    bus.pause = 1'b1; cycle(); bus.pause = 1'b0;
    check_outs("pause_with_tick", 8'h00, 8'h01, 0, 0, 0, 0);

    // Reset mid-count.
    do_clear();
    do_load(8'h12, 8'h34);
    do_start(1'b0);
    check_outs("run_1234", 8'h12, 8'h34, 1, 0, 0, 0);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_outs("reset_in_run", 8'h00, 8'h00, 0, 0, 0, 0);

    // Random run against the seconds-count model.
    clk_1s = 1'b0;
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    m_tot = 0; m_state = 0; m_down = 1'b0; hist = '0; m_tick = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 3) == 0) clk_1s = ~clk_1s;
      r = int'($urandom_range(0, 99));
      bus.start = (r < 10) || (r >= 96);
      bus.pause = (r >= 10 && r < 14) || (r >= 96);
      bus.clear = (r >= 14 && r < 16);
      bus.load  = (r >= 16 && r < 20) && (m_state != 1);
      bus.mode_down = 1'($urandom_range(0, 1));
      bus.load_min = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      bus.load_sec = 8'($urandom);

      m_wrap = 1'b0;
      if (bus.clear) begin
        m_state = 0; m_tot = 0;
      end else if (bus.load && m_state != 1) begin
        m_state = 0;
        m_tot = (clampi(bus.load_min[7:4], MAXT) * 10 + clampi(bus.load_min[3:0], 9)) * 60
              + clampi(bus.load_sec[7:4], 5) * 10 + clampi(bus.load_sec[3:0], 9);
      end else if (bus.pause) begin
        if (m_state == 1) m_state = 2;
      end else if (bus.start && (m_state == 0 || m_state == 2)) begin
        m_down = bus.mode_down;
        m_state = (m_down && m_tot == 0) ? 3 : 1;
      end else if (m_tick && m_state == 1) begin
        if (!m_down) begin
          if (m_tot == MAX_TOTAL) begin m_tot = 0; m_wrap = 1'b1; end
          else m_tot = m_tot + 1;
        end else if (m_tot > 0) begin
          m_tot = m_tot - 1;
          if (m_tot == 0) m_state = 3;
        end
      end

      cycle();
      idle_cmds();
      hist = {hist[SYNC:0], clk_1s};
      m_tick = hist[SYNC] & ~hist[SYNC+1];
      check_outs("random", to_bcd(m_tot / 60), to_bcd(m_tot % 60), m_state == 1, m_state == 3,
                 m_wrap, m_tick);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
